// File: rtl/count_seq_pkg.sv
// ---------------------------------------------------------------------------
// count_seq_pkg
//
// Shared definitions for the count sequencer slice.
//
// Contents:
//   CW_DEFAULT / PW_DEFAULT  default widths of the count value and pass count
//   state_t                  2-bit FSM state type
//   ST_IDLE / ST_COUNT /
//   ST_DONE                  the only three FSM states
// ---------------------------------------------------------------------------
package count_seq_pkg;

  localparam int CW_DEFAULT = 3;
  localparam int PW_DEFAULT = 4;

  // The states are kept as plain constants rather than an enum, so that
  // older tools and existing netlists keep seeing the same encoding.
  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage : count_seq_pkg

// File: rtl/down_cntr_dp.sv
// ---------------------------------------------------------------------------
// down_cntr_dp
//
// Loadable down-counter datapath used by count_sequencer. It has no notion
// of passes or terminal values. The controller decides each cycle whether
// to load, decrement or hold.
//
// Ports:
//   clk    rising-edge clock
//   clear  synchronous active-high reset; forces q to 0; wins over load/dec
//   load   load din into q (wins over dec)
//   dec    decrement q by one
//   din    value loaded when load is high
//   q      registered count value
// ---------------------------------------------------------------------------
module down_cntr_dp
  import count_seq_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] din,
  output logic [CW-1:0] q
);

  localparam logic [CW-1:0] ONE = CW'(1);

  // NOTE: sequential state is updated with <= only. All registers then
  // sample their pre-edge values, whatever order the blocks are in.
  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (dec) begin
      q <= q - ONE;
    end
  end

endmodule : down_cntr_dp

// File: rtl/count_sequencer.sv
// ---------------------------------------------------------------------------
// count_sequencer
//
// Runs a number of down-count passes from a latched upper value (hi) to a
// latched terminal value (lo). Each pass lasts hi-lo+1 unpaused cycles.
// When the final pass completes, the block enters a single DONE cycle and
// then returns to IDLE.
//
// Parameters:
//   CW        width of the count value (hi, lo, q)
//   PW        width of the pass count (passes, pass_cnt)
//
// Ports:
//   clk       rising-edge clock
//   clear     synchronous active-high reset; overrides every other input
//   start     begin a sequence; only looked at in IDLE
//   hi        load value of each pass (sampled on the accepting cycle)
//   lo        terminal value of each pass (sampled on the accepting cycle)
//   passes    number of passes to run (sampled on the accepting cycle)
//   pause     freeze count, pass count and state while high
//   abort     drop back to IDLE from COUNT; wins over pause and completion
//   q         registered count value
//   busy      high while in COUNT
//   tc        1-cycle pulse in the cycle after a pass reaches lo
//   done      1-cycle pulse marking normal completion (coincides with the
//             final tc)
//   err       1-cycle pulse after a start with lo>hi or passes==0
//   pass_cnt  passes completed; held in IDLE until the next accepted start
// ---------------------------------------------------------------------------
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int CW = CW_DEFAULT,
  parameter int PW = PW_DEFAULT
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          start,
  input  logic [CW-1:0] hi,
  input  logic [CW-1:0] lo,
  input  logic [PW-1:0] passes,
  input  logic          pause,
  input  logic          abort,
  output logic [CW-1:0] q,
  output logic          busy,
  output logic          tc,
  output logic          done,
  output logic          err,
  output logic [PW-1:0] pass_cnt
);

  localparam logic [PW:0] PASS_ONE = (PW + 1)'(1);

  state_t        state;
  state_t        state_nx;

  // Parameters of the running sequence, captured on the accepting cycle so
  // that the live inputs may change freely afterwards.
  logic [CW-1:0] hi_r;
  logic [CW-1:0] lo_r;
  logic [PW-1:0] passes_r;

  logic          accept;     // start request with a legal range/pass count
  logic          run;        // COUNT and neither aborting nor paused
  logic          at_lo;      // the current pass has reached its terminal value
  logic [PW:0]   pass_inc;   // pass count after the pass in progress
  logic          last_pass;  // the pass in progress is the final one

  logic          dp_load;
  logic          dp_dec;
  logic [CW-1:0] dp_din;

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  assign accept    = start && (lo <= hi) && (passes != '0);
  assign run       = (state == ST_COUNT) && !abort && !pause;
  assign at_lo     = (q == lo_r);

  // One extra bit, so the increment cannot wrap when pass_cnt is at its
  // maximum.
  assign pass_inc  = {1'b0, pass_cnt} + PASS_ONE;
  assign last_pass = (pass_inc >= {1'b0, passes_r});

  // The counter is loaded in two cases: from the live hi input when a
  // sequence is accepted, and from the latched hi when a pass that is not
  // the last one ends. After the final pass, q is left at lo.
  assign dp_load = ((state == ST_IDLE) && accept) ||
                   (run && at_lo && !last_pass);
  assign dp_dec  = run && !at_lo;
  assign dp_din  = (state == ST_IDLE) ? hi : hi_r;

  assign busy    = (state == ST_COUNT);

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  down_cntr_dp #(
    .CW (CW)
  ) u_dp (
    .clk   (clk),
    .clear (clear),
    .load  (dp_load),
    .dec   (dp_dec),
    .din   (dp_din),
    .q     (q)
  );

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: state_nx gets a default before the case statement. This keeps
  // the block purely combinational, so no latch is inferred on any path.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (run && at_lo && last_pass) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State, latched parameters, pass tracking and pulses
  // -------------------------------------------------------------------------
  // NOTE: the latched hi/lo/passes are cleared along with the control
  // state. Nothing reads them outside COUNT, but clearing them keeps the
  // block free of X after reset in simulation and in equivalence checking.
  always_ff @(posedge clk) begin
    if (clear) begin
      state    <= ST_IDLE;
      hi_r     <= '0;
      lo_r     <= '0;
      passes_r <= '0;
      pass_cnt <= '0;
      tc       <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_nx;
      tc    <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;

      if ((state == ST_IDLE) && start) begin
        if (accept) begin
          hi_r     <= hi;
          lo_r     <= lo;
          passes_r <= passes;
          pass_cnt <= '0;
        end else begin
          err <= 1'b1;
        end
      end

      // A pass completes on an unpaused, unaborted cycle at lo. done is set
      // on the same edge as the final tc, so both pulses appear during the
      // DONE cycle.
      if (run && at_lo) begin
        tc       <= 1'b1;
        pass_cnt <= pass_inc[PW-1:0];
        if (last_pass) begin
          done <= 1'b1;
        end
      end
    end
  end

endmodule : count_sequencer

// File: tb/tb_count_sequencer.sv
// ---------------------------------------------------------------------------
// tb_count_sequencer
//
// Self-checking bench for count_sequencer. A behavioural model tracks how
// many productive (unpaused) cycles a sequence has consumed and derives q,
// pass_cnt and the pulses arithmetically. A negedge compare process checks
// every output against the model on every cycle. Directed scenarios add
// literal expectations; a long randomized phase follows.
// ---------------------------------------------------------------------------
module tb_count_sequencer;

  localparam int CW = 3;
  localparam int PW = 4;

  logic          clk;
  logic          clear;
  logic          start;
  logic [CW-1:0] hi;
  logic [CW-1:0] lo;
  logic [PW-1:0] passes;
  logic          pause;
  logic          abort;
  logic [CW-1:0] q;
  logic          busy;
  logic          tc;
  logic          done;
  logic          err;
  logic [PW-1:0] pass_cnt;

  count_sequencer #(
    .CW (CW),
    .PW (PW)
  ) dut (
    .clk      (clk),
    .clear    (clear),
    .start    (start),
    .hi       (hi),
    .lo       (lo),
    .passes   (passes),
    .pause    (pause),
    .abort    (abort),
    .q        (q),
    .busy     (busy),
    .tc       (tc),
    .done     (done),
    .err      (err),
    .pass_cnt (pass_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model.
  // A sequence of P passes over [lo..hi] is L*P productive cycles long,
  // where L = hi-lo+1. After k productive cycles, q = hi - (k mod L) and
  // pass_cnt = k div L. A pass boundary (k mod L == 0) gives a tc. At
  // k == L*P the sequence is finished.
  // -------------------------------------------------------------------------
  bit m_run;
  bit m_fin;
  int m_hi, m_lo, m_np, m_k;
  int exp_q, exp_pc;
  bit exp_busy, exp_tc, exp_done, exp_err;

  task model_update();
    int len;
    exp_tc   = 1'b0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (clear) begin
      m_run  = 1'b0;
      m_fin  = 1'b0;
      exp_q  = 0;
      exp_pc = 0;
    end else if (m_fin) begin
      m_fin = 1'b0;
    end else if (!m_run) begin
      if (start) begin
        if (int'(lo) <= int'(hi) && passes != 0) begin
          m_run  = 1'b1;
          m_hi   = int'(hi);
          m_lo   = int'(lo);
          m_np   = int'(passes);
          m_k    = 0;
          exp_q  = m_hi;
          exp_pc = 0;
        end else begin
          exp_err = 1'b1;
        end
      end
    end else if (abort) begin
      m_run = 1'b0;
    end else if (!pause) begin
      len = m_hi - m_lo + 1;
      m_k++;
      if (m_k == len * m_np) begin
        m_run    = 1'b0;
        m_fin    = 1'b1;
        exp_tc   = 1'b1;
        exp_done = 1'b1;
        exp_q    = m_lo;
        exp_pc   = m_np;
      end else begin
        exp_q  = m_hi - (m_k % len);
        exp_pc = m_k / len;
        exp_tc = ((m_k % len) == 0);
      end
    end
    exp_busy = m_run;
  endtask

  // Inputs are set just after a posedge. The model is advanced at the next
  // posedge, using the same input values the DUT samples there.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("q",        32'(q),        32'(exp_q));
      check("busy",     32'(busy),     32'(exp_busy));
      check("tc",       32'(tc),       32'(exp_tc));
      check("done",     32'(done),     32'(exp_done));
      check("err",      32'(err),      32'(exp_err));
      check("pass_cnt", 32'(pass_cnt), 32'(exp_pc));
    end
  end

  initial begin
    int nom_q[8];
    nom_q = '{5, 4, 3, 2, 5, 4, 3, 2};

    clear = 1'b1; start = 1'b0; hi = '0; lo = '0; passes = '0;
    pause = 1'b0; abort = 1'b0;
    step();
    chk_en = 1'b1;
    check("rst_q",    32'(q),        0);
    check("rst_busy", 32'(busy),     0);
    check("rst_pc",   32'(pass_cnt), 0);
    check("rst_puls", 32'({tc, done, err}), 0);
    clear = 1'b0;
    step();

    // Nominal run: hi=5, lo=2, two passes. The live inputs are scrambled
    // after acceptance and must have no effect.
    hi = 3'd5; lo = 3'd2; passes = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    check("nom_q0",    32'(q),    5);
    check("nom_busy0", 32'(busy), 1);
    check("nom_pc0",   32'(pass_cnt), 0);
    for (int i = 1; i < 8; i++) begin
      hi = 3'($urandom_range(0, 7)); lo = 3'($urandom_range(0, 7));
      passes = 4'($urandom_range(0, 15));
      step();
      check("nom_q",    32'(q),    32'(nom_q[i]));
      check("nom_busy", 32'(busy), 1);
      check("nom_tc",   32'(tc),   (i == 4) ? 1 : 0);
    end
    step();
    check("nom_done", 32'(done),     1);
    check("nom_tc2",  32'(tc),       1);
    check("nom_busy", 32'(busy),     0);
    check("nom_pc",   32'(pass_cnt), 2);
    check("nom_qend", 32'(q),        2);
    step();
    check("nom_idle_pc", 32'(pass_cnt), 2);
    check("nom_idle_dn", 32'(done),     0);

    // Rejected starts: inverted range, then a zero pass count.
    hi = 3'd1; lo = 3'd3; passes = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    check("rej_err",  32'(err),  1);
    check("rej_busy", 32'(busy), 0);
    check("rej_q",    32'(q),    2);
    step();
    check("rej_err0", 32'(err),  0);
    hi = 3'd3; lo = 3'd1; passes = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    check("rej0_err", 32'(err),  1);
    check("rej0_bsy", 32'(busy), 0);
    step();

    // Degenerate range hi == lo: 1-cycle passes with no decrement.
    hi = 3'd4; lo = 3'd4; passes = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    check("deg_q",  32'(q),  4);
    check("deg_tc", 32'(tc), 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("deg_tc", 32'(tc),       1);
      check("deg_pc", 32'(pass_cnt), 32'(i));
      check("deg_dn", 32'(done),     (i == 3) ? 1 : 0);
      check("deg_q",  32'(q),        4);
    end
    step();

    // Pause at q=5, then abort while still paused.
    hi = 3'd7; lo = 3'd0; passes = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("pa_q5", 32'(q), 5);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("pa_hold", 32'(q),    5);
      check("pa_tc",   32'(tc),   0);
      check("pa_busy", 32'(busy), 1);
    end
    abort = 1'b1;
    step();
    abort = 1'b0; pause = 1'b0;
    check("ab_busy", 32'(busy), 0);
    check("ab_q",    32'(q),    5);
    check("ab_done", 32'(done), 0);
    step();
    check("ab_idle", 32'(busy), 0);

    // Clear mid-sequence, with start held high the whole time.
    hi = 3'd5; lo = 3'd1; passes = 4'd2; start = 1'b1;
    step();
    step();
    step();
    check("rm_q3",  32'(q),        3);
    check("rm_pc",  32'(pass_cnt), 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("rm_q",    32'(q),        0);
    check("rm_pc0",  32'(pass_cnt), 0);
    check("rm_busy", 32'(busy),     0);
    check("rm_puls", 32'({tc, done, err}), 0);
    hi = 3'd2; lo = 3'd0; passes = 4'd1;
    step();
    start = 1'b0;
    check("rm_start", 32'(busy), 1);
    check("rm_qhi",   32'(q),    2);
    for (int i = 0; i < 5; i++) step();

    // Randomized phase.
    for (int c = 0; c < 4000; c++) begin
      clear = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 99) < 30);
      pause = ($urandom_range(0, 99) < 20);
      abort = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 9) < 7) begin
        lo = 3'($urandom_range(0, 7));
        hi = 3'($urandom_range(int'(lo), 7));
      end else begin
        hi = 3'($urandom_range(0, 7));
        lo = 3'($urandom_range(0, 7));
      end
      passes = 4'($urandom_range(0, 3));
      step();
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_count_sequencer
